// File: rtl/mtx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mtx_frame_scheduler
// Purpose  : Byte-slot framer (preamble, SFD, payload, gap) for the Manchester TX path.
// Revision : 1.0 - initial release
// ============================================================================
module mtx_frame_scheduler #(
  parameter int unsigned PREAMBLE_LEN  = 2,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
  parameter logic [7:0]  SFD_BYTE      = 8'hD5,
  parameter int unsigned MAX_PAYLOAD   = 255,
  parameter int unsigned GAP_SLOTS     = 4
) (
  input  logic       clk_div,
  input  logic       aresetn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] tx_byte,
  output logic       tx_phase,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underrun,
  output logic       err_overflow
);

  localparam logic [3:0] C_PRE_LEN = 4'(PREAMBLE_LEN);
  localparam logic [3:0] C_GAP_M1  = 4'(GAP_SLOTS - 1);
  localparam logic [7:0] C_MAX     = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  state_t     r_state,    w_state_nxt;
  logic       r_phase;
  logic [7:0] r_tx_byte,  w_tx_byte_nxt;
  logic       r_tx_en,    w_tx_en_nxt;
  logic [3:0] r_pre_cnt,  w_pre_cnt_nxt;
  logic [3:0] r_gap_cnt,  w_gap_cnt_nxt;
  logic [7:0] r_pay_cnt,  w_pay_cnt_nxt;
  logic       r_cur_last, w_cur_last_nxt;
  logic       w_need_byte;
  logic       w_ready;

  // A new byte is owed for the next slot in SFD, or mid-payload below the cap.
  assign w_need_byte = (r_state == ST_SFD) ||
                       ((r_state == ST_PAYLOAD) && !r_cur_last && (r_pay_cnt < C_MAX));
  assign w_ready     = (r_phase && w_need_byte) || (r_state == ST_DRAIN);

  assign s_tready     = w_ready;
  assign tx_byte      = r_tx_byte;
  assign tx_phase     = r_phase;
  assign tx_en        = r_tx_en;
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = r_phase && (r_state == ST_PAYLOAD) && r_cur_last;
  assign err_underrun = r_phase && w_need_byte && !s_tvalid;
  assign err_overflow = r_phase && (r_state == ST_PAYLOAD) && !r_cur_last &&
                        (r_pay_cnt == C_MAX);

  always_ff @(posedge clk_div or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_phase    <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_tx_en    <= 1'b0;
      r_pre_cnt  <= 4'd0;
      r_gap_cnt  <= 4'd0;
      r_pay_cnt  <= 8'd0;
      r_cur_last <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= ~r_phase;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_en    <= w_tx_en_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_pay_cnt  <= w_pay_cnt_nxt;
      r_cur_last <= w_cur_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_byte_nxt  = r_tx_byte;
    w_tx_en_nxt    = r_tx_en;
    w_pre_cnt_nxt  = r_pre_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_pay_cnt_nxt  = r_pay_cnt;
    w_cur_last_nxt = r_cur_last;

    case (r_state)
      ST_IDLE: begin
        if (r_phase && s_tvalid) begin
          w_state_nxt    = ST_PREAMBLE;
          w_tx_byte_nxt  = PREAMBLE_BYTE;
          w_tx_en_nxt    = 1'b1;
          w_pre_cnt_nxt  = 4'd1;
          w_pay_cnt_nxt  = 8'd0;
          w_cur_last_nxt = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        if (r_phase) begin
          if (r_pre_cnt == C_PRE_LEN) begin
            w_state_nxt   = ST_SFD;
            w_tx_byte_nxt = SFD_BYTE;
          end else begin
            w_pre_cnt_nxt = r_pre_cnt + 4'd1;
          end
        end
      end
      ST_SFD, ST_PAYLOAD: begin
        if (r_phase) begin
          if (w_need_byte && s_tvalid) begin
            w_state_nxt    = ST_PAYLOAD;
            w_tx_byte_nxt  = s_tdata;
            w_cur_last_nxt = s_tlast;
            w_pay_cnt_nxt  = r_pay_cnt + 8'd1;
          end else if (w_need_byte || r_cur_last) begin
            // Underrun or normal end: both fall straight into the gap.
            w_state_nxt   = ST_GAP;
            w_tx_byte_nxt = 8'h00;
            w_tx_en_nxt   = 1'b0;
            w_gap_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt   = ST_DRAIN;
            w_tx_byte_nxt = 8'h00;
            w_tx_en_nxt   = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (s_tvalid && s_tlast) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = 4'd0;
        end
      end
      ST_GAP: begin
        if (r_phase) begin
          if (r_gap_cnt == C_GAP_M1) begin
            // Back-to-back frames start right after the last gap slot.
            if (s_tvalid) begin
              w_state_nxt    = ST_PREAMBLE;
              w_tx_byte_nxt  = PREAMBLE_BYTE;
              w_tx_en_nxt    = 1'b1;
              w_pre_cnt_nxt  = 4'd1;
              w_pay_cnt_nxt  = 8'd0;
              w_cur_last_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
